// File: rtl/expipe_pkg.sv
// Execution-pipeline shared types, including the result record broadcast on the CDB.
package expipe_pkg;

    import len5_config_pkg::*;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0]     rob_idx;
        logic [XLEN-1:0]            res_value;
        logic                       except_raised;
        logic [EXCEPT_CODE_LEN-1:0] except_code;
    } cdb_data_t;

endpackage

// File: rtl/len5_config_pkg.sv
// Global configuration constants: datapath widths and per-unit CDB result buffer depths.
package len5_config_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned ROB_IDX_LEN        = 6;
    localparam int unsigned EXCEPT_CODE_LEN    = 5;

    // Default result buffer depth for each execution unit feeding a low-priority CDB lane
    localparam int unsigned ALU_CDB_BUF_DEPTH  = 2;
    localparam int unsigned MULT_CDB_BUF_DEPTH = 2;

endpackage

// File: rtl/cdb_result_buffer.sv
// In-order result FIFO between one execution unit and its low-priority CDB lane.
// All outputs come from registered state only; there is no push-to-pop bypass.
module cdb_result_buffer
    import expipe_pkg::*;
#(
    parameter int unsigned DEPTH = len5_config_pkg::ALU_CDB_BUF_DEPTH
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      flush_i,
    input  logic      eu_valid_i,
    output logic      eu_ready_o,
    input  cdb_data_t eu_data_i,
    output logic      cdb_valid_o,
    input  logic      cdb_ready_i,
    output cdb_data_t cdb_data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cdb_data_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign eu_ready_o  = (count != CNT_W'(DEPTH));
    assign cdb_valid_o = (count != '0);
    assign cdb_data_o  = mem[head];

    assign push = eu_valid_i & eu_ready_o;
    assign pop  = cdb_valid_o & cdb_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage is left unreset; contents are only observable while the count says valid
    always_ff @(posedge clk_i) begin
        if (push) mem[tail] <= eu_data_i;
    end

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (count == CNT_W'(DEPTH))));
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= CNT_W'(DEPTH));
    a_depth_legal: assert property (@(posedge clk_i)
        (DEPTH >= 1) && (DEPTH <= 16));
`endif

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Scoreboard bench for cdb_result_buffer: a DEPTH=2 instance and a DEPTH=3 instance.
module tb_cdb_result_buffer;

    import len5_config_pkg::*;
    import expipe_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      a_flush, a_eu_valid, a_eu_ready, a_cdb_valid, a_cdb_ready;
    cdb_data_t a_eu_data, a_cdb_data;
    logic      b_flush, b_eu_valid, b_eu_ready, b_cdb_valid, b_cdb_ready;
    cdb_data_t b_eu_data, b_cdb_data;

    cdb_data_t sb_a[$];
    cdb_data_t sb_b[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_result_buffer #(.DEPTH(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .eu_valid_i(a_eu_valid), .eu_ready_o(a_eu_ready), .eu_data_i(a_eu_data),
        .cdb_valid_o(a_cdb_valid), .cdb_ready_i(a_cdb_ready), .cdb_data_o(a_cdb_data)
    );

    cdb_result_buffer #(.DEPTH(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .eu_valid_i(b_eu_valid), .eu_ready_o(b_eu_ready), .eu_data_i(b_eu_data),
        .cdb_valid_o(b_cdb_valid), .cdb_ready_i(b_cdb_ready), .cdb_data_o(b_cdb_data)
    );

    function automatic cdb_data_t mk(input int rob, input logic [31:0] val);
        cdb_data_t r;
        r.rob_idx       = ROB_IDX_LEN'(rob);
        r.res_value     = val;
        r.except_raised = rob[0];
        r.except_code   = EXCEPT_CODE_LEN'(rob + 3);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted CDB transfer must match the oldest expected result
    initial begin
        cdb_data_t exp;
        forever begin
            @(negedge clk);
            if (rst_n && a_cdb_valid && a_cdb_ready) begin
                if (sb_a.size() == 0) chk("a_unexpected_out", 64'(a_cdb_data), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    exp = sb_a.pop_front();
                    chk("a_out_data", 64'(a_cdb_data), 64'(exp));
                end
            end
            if (rst_n && b_cdb_valid && b_cdb_ready) begin
                if (sb_b.size() == 0) chk("b_unexpected_out", 64'(b_cdb_data), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    exp = sb_b.pop_front();
                    chk("b_out_data", 64'(b_cdb_data), 64'(exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        a_flush = 1'b0; a_eu_valid = 1'b1; a_eu_data = mk(9, 32'h0000_0009); a_cdb_ready = 1'b0;
        b_flush = 1'b0; b_eu_valid = 1'b0; b_eu_data = mk(0, 32'h0);         b_cdb_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(a_cdb_valid), 64'd0);
        chk("rst_ready", 64'(a_eu_ready), 64'd1);
        cyc();
        chk("rst_edge_valid", 64'(a_cdb_valid), 64'd0);
        chk("rst_edge_ready", 64'(a_eu_ready), 64'd1);
        rst_n = 1'b1; a_eu_valid = 1'b0;
        cyc();

        // First push after reset, no bypass
        a_eu_valid = 1'b1; a_eu_data = mk(3, 32'hDEAD_BEEF); sb_a.push_back(mk(3, 32'hDEAD_BEEF));
        #1 chk("no_bypass", 64'(a_cdb_valid), 64'd0);
        cyc();
        a_eu_valid = 1'b0;
        chk("first_valid", 64'(a_cdb_valid), 64'd1);
        chk("first_data", 64'(a_cdb_data), 64'(mk(3, 32'hDEAD_BEEF)));
        a_cdb_ready = 1'b1;
        cyc();
        a_cdb_ready = 1'b0;
        chk("first_drained", 64'(a_cdb_valid), 64'd0);

        // Fill and stall
        a_eu_valid = 1'b1; a_eu_data = mk(1, 32'h1111_0001); sb_a.push_back(mk(1, 32'h1111_0001));
        cyc();
        chk("fill1_ready", 64'(a_eu_ready), 64'd1);
        a_eu_data = mk(2, 32'h2222_0002); sb_a.push_back(mk(2, 32'h2222_0002));
        cyc();
        chk("full_ready", 64'(a_eu_ready), 64'd0);
        chk("full_head", 64'(a_cdb_data), 64'(mk(1, 32'h1111_0001)));
        a_eu_data = mk(3, 32'h3333_0003);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_ready", 64'(a_eu_ready), 64'd0);
            chk("stall_head", 64'(a_cdb_data), 64'(mk(1, 32'h1111_0001)));
        end
        a_cdb_ready = 1'b1;
        cyc();
        a_cdb_ready = 1'b0;
        chk("after_pop_ready", 64'(a_eu_ready), 64'd1);
        chk("after_pop_head", 64'(a_cdb_data), 64'(mk(2, 32'h2222_0002)));
        sb_a.push_back(mk(3, 32'h3333_0003));
        cyc();
        a_eu_valid = 1'b0;
        chk("refill_ready", 64'(a_eu_ready), 64'd0);
        a_cdb_ready = 1'b1;
        cyc();
        cyc();
        a_cdb_ready = 1'b0;
        chk("stall_drained", 64'(a_cdb_valid), 64'd0);

        // Streaming: one in, one out per cycle
        for (int i = 0; i < 16; i++) begin
            a_eu_valid = 1'b1; a_cdb_ready = 1'b1;
            a_eu_data = mk(i, 32'hA5A5_0000 + 32'(i)); sb_a.push_back(mk(i, 32'hA5A5_0000 + 32'(i)));
            cyc();
            chk("stream_valid", 64'(a_cdb_valid), 64'd1);
            chk("stream_ready", 64'(a_eu_ready), 64'd1);
        end
        a_eu_valid = 1'b0;
        cyc();
        a_cdb_ready = 1'b0;
        chk("stream_drained", 64'(a_cdb_valid), 64'd0);

        // Flush with two held and a third offered
        a_eu_valid = 1'b1; a_eu_data = mk(20, 32'h0000_0020);
        cyc();
        a_eu_data = mk(21, 32'h0000_0021);
        cyc();
        a_eu_data = mk(22, 32'h0000_0022); a_flush = 1'b1;
        cyc();
        a_flush = 1'b0; a_eu_valid = 1'b0;
        chk("flush_valid", 64'(a_cdb_valid), 64'd0);
        chk("flush_ready", 64'(a_eu_ready), 64'd1);
        a_cdb_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        a_cdb_ready = 1'b0;

        // Asynchronous reset between edges
        a_eu_valid = 1'b1; a_eu_data = mk(30, 32'h0000_0030);
        cyc();
        a_eu_data = mk(31, 32'h0000_0031);
        cyc();
        a_eu_valid = 1'b0;
        chk("pre_areset_valid", 64'(a_cdb_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("areset_valid", 64'(a_cdb_valid), 64'd0);
        chk("areset_ready", 64'(a_eu_ready), 64'd1);
        #2 rst_n = 1'b1;
        cyc();
        chk("post_areset_valid", 64'(a_cdb_valid), 64'd0);
        a_eu_valid = 1'b1; a_eu_data = mk(32, 32'h0000_0032); sb_a.push_back(mk(32, 32'h0000_0032));
        cyc();
        a_eu_valid = 1'b0;
        chk("post_areset_data", 64'(a_cdb_data), 64'(mk(32, 32'h0000_0032)));
        a_cdb_ready = 1'b1;
        cyc();
        a_cdb_ready = 1'b0;

        // DEPTH=3: pointer wrap under sustained push/pop at count=1
        b_eu_valid = 1'b1; b_eu_data = mk(40, 32'hB000_0040); sb_b.push_back(mk(40, 32'hB000_0040));
        cyc();
        for (int i = 0; i < 20; i++) begin
            b_eu_valid = 1'b1; b_cdb_ready = 1'b1;
            b_eu_data = mk(41 + i, 32'hB000_0041 + 32'(i)); sb_b.push_back(mk(41 + i, 32'hB000_0041 + 32'(i)));
            cyc();
            chk("wrap_valid", 64'(b_cdb_valid), 64'd1);
            chk("wrap_ready", 64'(b_eu_ready), 64'd1);
        end
        b_eu_valid = 1'b0;
        cyc();
        b_cdb_ready = 1'b0;
        chk("wrap_drained", 64'(b_cdb_valid), 64'd0);

        // DEPTH=3: fill to the boundary after wrapping
        for (int i = 0; i < 3; i++) begin
            b_eu_valid = 1'b1; b_eu_data = mk(61 + i, 32'hC000_0000 + 32'(i));
            sb_b.push_back(mk(61 + i, 32'hC000_0000 + 32'(i)));
            cyc();
        end
        b_eu_valid = 1'b0;
        chk("b_full_ready", 64'(b_eu_ready), 64'd0);
        chk("b_full_head", 64'(b_cdb_data), 64'(mk(61, 32'hC000_0000)));
        b_cdb_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        b_cdb_ready = 1'b0;
        chk("b_full_drained", 64'(b_cdb_valid), 64'd0);

        chk("a_sb_empty", 64'(sb_a.size()), 64'd0);
        chk("b_sb_empty", 64'(sb_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
